// File: rtl/axi_rw_checker.sv
// axi_rw_checker
// Single-master AXI4 traffic engine: writes one burst of a known address-derived
// pattern starting at an aligned base, reads the same region back and checks
// every returned beat. Completion and error status are sticky until the next
// accepted start.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   setting_i, start_i    start byte address (sampled on start), start pulse
//   rw_done_o[1:0]        [0] write phase done, [1] read/check phase done
//   error_o, err_count_o  sticky error flag, saturating error count
//   aw*/w*/b*/ar*/r*      AXI4 master channels (512-bit data, fixed id 0)
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | waiting for start
// S_AW   | presenting write address
// S_W    | streaming write beats
// S_B    | waiting for write response
// S_AR   | presenting read address
// S_R    | receiving and checking read beats
// S_DONE | test finished; R still accepted unchecked; start restarts
module axi_rw_checker #(
    parameter int unsigned BURST_LEN = 16,
    parameter logic [31:0] SEED      = 32'h0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  setting_i,
    input  logic         start_i,
    output logic [1:0]   rw_done_o,
    output logic         error_o,
    output logic [15:0]  err_count_o,
    output logic [63:0]  awaddr_o,
    output logic [7:0]   awlen_o,
    output logic [2:0]   awsize_o,
    output logic [15:0]  awid_o,
    output logic         awvalid_o,
    input  logic         awready_i,
    output logic [511:0] wdata_o,
    output logic [63:0]  wstrb_o,
    output logic         wlast_o,
    output logic         wvalid_o,
    input  logic         wready_i,
    input  logic [1:0]   bresp_i,
    input  logic         bvalid_i,
    output logic         bready_o,
    output logic [63:0]  araddr_o,
    output logic [7:0]   arlen_o,
    output logic [2:0]   arsize_o,
    output logic [15:0]  arid_o,
    output logic         arvalid_o,
    input  logic         arready_i,
    input  logic [511:0] rdata_i,
    input  logic [1:0]   rresp_i,
    input  logic         rlast_i,
    input  logic         rvalid_i,
    output logic         rready_o
);

    localparam int unsigned ALIGN_BITS = $clog2(BURST_LEN * 64);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_BITS) - 32'd1);
    localparam logic [6:0]  LAST_BEAT  = 7'(BURST_LEN - 1);
    localparam logic [7:0]  AXLEN      = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [31:0]  base_q, base_d;
    logic [7:0]   len_q, len_d;
    logic [6:0]   beat_q, beat_d;
    logic [1:0]   done_q, done_d;
    logic         error_q, error_d;
    logic [15:0]  errs_q, errs_d;
    logic [511:0] exp_data;
    logic [1:0]   inc;
    logic         clear;
    logic [16:0]  sum;

    // Lane i of beat b carries the byte address of that lane, keyed by SEED.
    function automatic logic [511:0] pattern(input logic [31:0] base, input logic [6:0] beat);
        logic [511:0] data;
        logic [31:0]  row;
        row = base + {19'd0, beat, 6'd0};
        for (int i = 0; i < 16; i++) begin
            data[i*32 +: 32] = (row + 32'(i * 4)) ^ SEED;
        end
        return data;
    endfunction

    assign exp_data = pattern(base_q, beat_q);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        beat_d    = beat_q;
        done_d    = done_q;
        error_d   = error_q;
        inc       = 2'd0;
        clear     = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        bready_o  = 1'b0;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                rready_o = (state_q == S_DONE);
                if (start_i) begin
                    base_d  = setting_i & ALIGN_MASK;
                    len_d   = AXLEN;
                    beat_d  = 7'd0;
                    done_d  = 2'b00;
                    error_d = 1'b0;
                    clear   = 1'b1;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                awvalid_o = 1'b1;
                if (awready_i) state_d = S_W;
            end
            S_W: begin
                wvalid_o = 1'b1;
                if (wready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 7'd0;
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end
            end
            S_B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    done_d[0] = 1'b1;
                    if (bresp_i != 2'b00) inc = 2'd1;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                arvalid_o = 1'b1;
                if (arready_i) state_d = S_R;
            end
            S_R: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    // A bad beat counts once; a premature rlast is an extra error.
                    inc = {1'b0, (rdata_i != exp_data) || (rresp_i != 2'b00)}
                        + {1'b0, rlast_i && (beat_q != LAST_BEAT)};
                    if (rlast_i || beat_q == LAST_BEAT) begin
                        done_d[1] = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (inc != 2'd0) error_d = 1'b1;
        sum = {1'b0, errs_q} + {15'd0, inc};
        if (clear) errs_d = 16'd0;
        else if (sum[16]) errs_d = 16'hFFFF;
        else errs_d = sum[15:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            base_q  <= 32'd0;
            len_q   <= 8'd0;
            beat_q  <= 7'd0;
            done_q  <= 2'b00;
            error_q <= 1'b0;
            errs_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            error_q <= error_d;
            errs_q  <= errs_d;
        end
    end

    assign rw_done_o   = done_q;
    assign error_o     = error_q;
    assign err_count_o = errs_q;
    assign awaddr_o    = {32'd0, base_q};
    assign araddr_o    = {32'd0, base_q};
    assign awlen_o     = len_q;
    assign arlen_o     = len_q;
    assign awsize_o    = 3'd6;
    assign arsize_o    = 3'd6;
    assign awid_o      = 16'd0;
    assign arid_o      = 16'd0;
    assign wdata_o     = (state_q == S_W) ? exp_data : 512'd0;
    assign wstrb_o     = (state_q == S_W) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
    assign wlast_o     = (state_q == S_W) && (beat_q == LAST_BEAT);

endmodule
